// File: rtl/pipe_stage7_scale_out_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stage7_scale_out_pkg
// Shared pipeline package: geometry defaults for the pipe stages, the common
// stage FSM state enum, and the bit-exact fp16 multiply used by the scaler.
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_stage7_scale_out_pkg;

  // Geometry defaults shared by every pipe stage
  localparam int WIDTH         = 16;
  localparam int PARALLEL_SIZE = 3;
  localparam int TILE_SIZE     = 128;
  localparam int BEAT_ELEMS    = 16;

  // Common stage FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } pipe_state_e;

  // Result of one fp16 multiply plus its status flags
  typedef struct packed {
    logic [15:0] result;
    logic        invalid;
    logic        overflow;
    logic        underflow;
  } fp16_mul_res_t;

  // IEEE-754 binary16 multiply, round-to-nearest-even, full subnormal support.
  // NaN inputs are returned quieted (first operand wins); inf*0 gives the
  // canonical quiet NaN 0x7E00.
  function automatic fp16_mul_res_t fp16_mul_f(input logic [15:0] a,
                                               input logic [15:0] b);
    fp16_mul_res_t r;
    logic          sign;
    logic          aNan, bNan, aInf, bInf, aZero, bZero;
    logic [10:0]   sigA, sigB;
    logic [21:0]   prod, norm;
    logic [43:0]   wide;
    logic [10:0]   sig;
    logic          guard, sticky, inc;
    logic [11:0]   sigR;
    logic [9:0]    mant;
    int            expA, expB, lead, expR, sh, expField;

    r     = '0;
    sign  = a[15] ^ b[15];
    aNan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'h0);
    bNan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'h0);
    aInf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'h0);
    bInf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'h0);
    aZero = (a[14:0] == 15'h0);
    bZero = (b[14:0] == 15'h0);

    if (aNan) begin
      r.result  = a | 16'h0200;
      r.invalid = ~a[9];
    end else if (bNan) begin
      r.result  = b | 16'h0200;
      r.invalid = ~b[9];
    end else if ((aInf && bZero) || (bInf && aZero)) begin
      r.result  = 16'h7E00;
      r.invalid = 1'b1;
    end else if (aInf || bInf) begin
      r.result = {sign, 5'h1F, 10'h0};
    end else if (aZero || bZero) begin
      r.result = {sign, 15'h0};
    end else begin
      // Subnormals use exponent 1 with no hidden bit
      sigA = {a[14:10] != 5'h0, a[9:0]};
      sigB = {b[14:10] != 5'h0, b[9:0]};
      expA = (a[14:10] == 5'h0) ? 1 : int'(a[14:10]);
      expB = (b[14:10] == 5'h0) ? 1 : int'(b[14:10]);
      prod = 22'(sigA) * 22'(sigB);

      lead = 0;
      for (int i = 0; i < 22; i++) begin
        if (prod[i]) lead = i;
      end

      // Biased exponent of the product once its leading one sits at bit 21
      expR = lead + expA + expB - 35;
      norm = prod << (21 - lead);

      // Results below the normal range are denormalised by shifting right
      if (expR < 1) begin
        sh   = 1 - expR;
        expR = 1;
        if (sh > 22) sh = 22;
      end else begin
        sh = 0;
      end

      wide   = {norm, 22'h0} >> sh;
      sig    = wide[43:33];
      guard  = wide[32];
      sticky = |wide[31:0];
      inc    = guard & (sticky | sig[0]);
      sigR   = {1'b0, sig} + {11'h0, inc};

      // Rounding can carry into a new leading bit or lift a subnormal to normal
      if (sigR[11]) begin
        expField = expR + 1;
        mant     = sigR[10:1];
      end else begin
        expField = sigR[10] ? expR : 0;
        mant     = sigR[9:0];
      end

      r.underflow = (expField == 0) && (guard | sticky);

      if (expField >= 31) begin
        r.result   = {sign, 5'h1F, 10'h0};
        r.overflow = 1'b1;
      end else begin
        r.result = {sign, 5'(expField), mant};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_stage7_scale_out_scale_beat.sv
// -----------------------------------------------------------------------------
// fp16_mul / scale_beat
// fp16_mul : one combinational fp16 multiplier with status flags.
//   a_i, b_i    - fp16 operands
//   result_o    - fp16 product
//   invalid_o   - signalling NaN or inf*0
//   overflow_o  - rounded to infinity
//   underflow_o - tiny and inexact
// scale_beat : BEAT_ELEMS fp16 multipliers sharing one scale operand.
//   elems_i - beat of fp16 elements
//   scale_i - fp16 scale applied to every element
//   prod_o  - scaled elements
// -----------------------------------------------------------------------------
module fp16_mul (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] result_o,
  output logic        invalid_o,
  output logic        overflow_o,
  output logic        underflow_o
);
  import pipe_stage7_scale_out_pkg::*;

  fp16_mul_res_t res;

  // Whole multiply is combinational; the caller registers the result
  always_comb begin
    res = fp16_mul_f(a_i, b_i);
  end

  assign result_o    = res.result;
  assign invalid_o   = res.invalid;
  assign overflow_o  = res.overflow;
  assign underflow_o = res.underflow;

endmodule

module scale_beat #(
  parameter int WIDTH      = pipe_stage7_scale_out_pkg::WIDTH,
  parameter int BEAT_ELEMS = pipe_stage7_scale_out_pkg::BEAT_ELEMS
) (
  input  logic [BEAT_ELEMS-1:0][WIDTH-1:0] elems_i,
  input  logic [WIDTH-1:0]                 scale_i,
  output logic [BEAT_ELEMS-1:0][WIDTH-1:0] prod_o
);

  // Status flags are not needed by this stage
  logic [BEAT_ELEMS-1:0] invalid_unused;
  logic [BEAT_ELEMS-1:0] overflow_unused;
  logic [BEAT_ELEMS-1:0] underflow_unused;

  // One multiplier per element, all fed by the same lane scale
  for (genvar j = 0; j < BEAT_ELEMS; j++) begin : g_mul
    fp16_mul u_mul (
      .a_i         (elems_i[j]),
      .b_i         (scale_i),
      .result_o    (prod_o[j]),
      .invalid_o   (invalid_unused[j]),
      .overflow_o  (overflow_unused[j]),
      .underflow_o (underflow_unused[j])
    );
  end

endmodule

// File: rtl/pipe_stage7_scale_out.sv
// -----------------------------------------------------------------------------
// pipe_stage7_scale_out
// Captures the accumulated tiles and per-lane scales from the previous stage,
// then streams them out scaled, BEAT_ELEMS elements per beat with ready/valid.
//   clk_i, rst_i  - clock, async active-high reset
//   start_i       - capture request (honoured only in IDLE)
//   acc_i         - accumulated tiles [lane][element]
//   scale_i       - fp16 scale per lane
//   busy_o        - high whenever not IDLE
//   out_valid_o   - beat valid
//   out_ready_i   - downstream accept
//   out_data_o    - scaled beat elements
//   out_lane_o    - lane index of current beat
//   out_beat_o    - beat index within lane
//   out_last_o    - final beat of the transfer
//   done_o        - one-cycle pulse after the final beat is accepted
// -----------------------------------------------------------------------------
module pipe_stage7_scale_out #(
  parameter int WIDTH         = pipe_stage7_scale_out_pkg::WIDTH,
  parameter int PARALLEL_SIZE = pipe_stage7_scale_out_pkg::PARALLEL_SIZE,
  parameter int TILE_SIZE     = pipe_stage7_scale_out_pkg::TILE_SIZE,
  parameter int BEAT_ELEMS    = pipe_stage7_scale_out_pkg::BEAT_ELEMS
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          start_i,
  input  logic [PARALLEL_SIZE-1:0][TILE_SIZE-1:0][WIDTH-1:0] acc_i,
  input  logic [PARALLEL_SIZE-1:0][WIDTH-1:0]           scale_i,
  output logic                                          busy_o,
  output logic                                          out_valid_o,
  input  logic                                          out_ready_i,
  output logic [BEAT_ELEMS-1:0][WIDTH-1:0]              out_data_o,
  output logic [((PARALLEL_SIZE > 1) ? $clog2(PARALLEL_SIZE) : 1)-1:0] out_lane_o,
  output logic [((TILE_SIZE/BEAT_ELEMS > 1) ? $clog2(TILE_SIZE/BEAT_ELEMS) : 1)-1:0] out_beat_o,
  output logic                                          out_last_o,
  output logic                                          done_o
);
  import pipe_stage7_scale_out_pkg::*;

  localparam int BEATS_PER_LANE = TILE_SIZE / BEAT_ELEMS;
  localparam int LANE_W = (PARALLEL_SIZE > 1) ? $clog2(PARALLEL_SIZE) : 1;
  localparam int BEAT_W = (BEATS_PER_LANE > 1) ? $clog2(BEATS_PER_LANE) : 1;

  pipe_state_e state_q, state_d;

  logic [PARALLEL_SIZE-1:0][TILE_SIZE-1:0][WIDTH-1:0] accBuf_q;
  logic [PARALLEL_SIZE-1:0][WIDTH-1:0]                scaleBuf_q;

  logic [LANE_W-1:0]                 lane_q, lane_d;
  logic [BEAT_W-1:0]                 beat_q, beat_d;
  logic [BEAT_ELEMS-1:0][WIDTH-1:0]  data_q, data_d;

  logic                              loadBeat;
  logic                              lastBeat;
  logic [TILE_SIZE*WIDTH-1:0]        laneFlat;
  logic [BEAT_ELEMS*WIDTH-1:0]       beatFlat;
  logic [BEAT_ELEMS-1:0][WIDTH-1:0]  beatElems;
  logic [BEAT_ELEMS-1:0][WIDTH-1:0]  beatProd;
  logic [WIDTH-1:0]                  laneScale;

  assign lastBeat = (lane_q == LANE_W'(PARALLEL_SIZE - 1)) &&
                    (beat_q == BEAT_W'(BEATS_PER_LANE - 1));

  // State register; reset drops straight back to IDLE, aborting any transfer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: STREAM leaves only once the final beat is accepted
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = LOAD;
      LOAD:    state_d = STREAM;
      STREAM:  if (out_ready_i && lastBeat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decode straight from the state; last is gated by valid so
  // it is never seen outside STREAM
  always_comb begin
    busy_o      = (state_q != IDLE);
    out_valid_o = (state_q == STREAM);
    done_o      = (state_q == DONE);
    out_last_o  = (state_q == STREAM) && lastBeat;
  end

  // Capture buffers; written only on the IDLE start edge so a busy transfer
  // always streams the data it started with
  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && start_i) begin
      accBuf_q   <= acc_i;
      scaleBuf_q <= scale_i;
    end
  end

  // Choose which beat to register next: LOAD primes (0,0); an accepted
  // non-final beat advances beat first and wraps into the next lane
  always_comb begin
    lane_d   = lane_q;
    beat_d   = beat_q;
    loadBeat = 1'b0;
    if (state_q == LOAD) begin
      lane_d   = '0;
      beat_d   = '0;
      loadBeat = 1'b1;
    end else if (state_q == STREAM && out_ready_i && !lastBeat) begin
      loadBeat = 1'b1;
      if (beat_q == BEAT_W'(BEATS_PER_LANE - 1)) begin
        beat_d = '0;
        lane_d = lane_q + LANE_W'(1);
      end else begin
        beat_d = beat_q + BEAT_W'(1);
      end
    end
  end

  // Slice the selected beat out of the selected lane tile
  always_comb begin
    laneFlat  = accBuf_q[lane_d];
    beatFlat  = (BEAT_ELEMS*WIDTH)'(laneFlat >> (int'(beat_d) * BEAT_ELEMS * WIDTH));
    beatElems = beatFlat;
    laneScale = scaleBuf_q[lane_d];
    data_d    = loadBeat ? beatProd : data_q;
  end

  scale_beat #(
    .WIDTH      (WIDTH),
    .BEAT_ELEMS (BEAT_ELEMS)
  ) u_scale_beat (
    .elems_i (beatElems),
    .scale_i (laneScale),
    .prod_o  (beatProd)
  );

  // Output beat registers; they only move when a new beat is loaded, which
  // keeps everything stable while downstream stalls
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lane_q <= '0;
      beat_q <= '0;
      data_q <= '0;
    end else if (loadBeat) begin
      lane_q <= lane_d;
      beat_q <= beat_d;
      data_q <= data_d;
    end
  end

  assign out_data_o = data_q;
  assign out_lane_o = lane_q;
  assign out_beat_o = beat_q;

endmodule

// File: tb/tb_pipe_stage7_scale_out.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage7_scale_out
// Directed bench for pipe_stage7_scale_out. Expected beats are pushed to a
// scoreboard queue when a capture is set up and popped as beats are accepted.
// -----------------------------------------------------------------------------
module tb_pipe_stage7_scale_out;

  localparam int P  = 3;
  localparam int T  = 128;
  localparam int B  = 16;
  localparam int W  = 16;
  localparam int NB = T / B;

  typedef struct {
    logic [1:0]   lane;
    logic [2:0]   beat;
    logic         last;
    logic [255:0] data;
  } exp_t;

  logic                         clk;
  logic                         rst_i;
  logic                         start_i;
  logic [P-1:0][T-1:0][W-1:0]   acc_i;
  logic [P-1:0][W-1:0]          scale_i;
  logic                         busy_o;
  logic                         out_valid_o;
  logic                         out_ready_i;
  logic [B-1:0][W-1:0]          out_data_o;
  logic [1:0]                   out_lane_o;
  logic [2:0]                   out_beat_o;
  logic                         out_last_o;
  logic                         done_o;

  exp_t        sb[$];
  logic [15:0] accPat [P][T];
  logic [15:0] scalePat [P];
  bit   [3:0]  readyPattern = 4'b1001;
  int          vectorCount = 0;
  int          missCount   = 0;

  pipe_stage7_scale_out dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .acc_i       (acc_i),
    .scale_i     (scale_i),
    .busy_o      (busy_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_lane_o  (out_lane_o),
    .out_beat_o  (out_beat_o),
    .out_last_o  (out_last_o),
    .done_o      (done_o)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference fp16 products for the operand classes used below
  function automatic logic [15:0] modelMul(input logic [15:0] a, input logic [15:0] s);
    if (s == 16'h0000)
      return ((a[14:10] == 5'h1F) && (a[9:0] != 10'h0)) ? 16'h7E00 : {a[15], 15'h0};
    if (s == 16'h3C00) return a;
    if (s == 16'h4000)
      return (a[14:10] == 5'h0) ? {a[15], a[13:0], 1'b0} : a + 16'h0400;
    if (s == 16'h3800) return a - 16'h0400;
    return 16'hxxxx;
  endfunction

  // One comparison: counts it, and reports and counts a miscompare
  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    vectorCount++;
    assert (obs === expv) else begin
      missCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Build one scenario's tiles and scales, drive them, queue expected beats
  task automatic applyStimulus(input int scen);
    exp_t e;
    for (int l = 0; l < P; l++) begin
      case (scen)
        1:       scalePat[l] = (l == 0) ? 16'h3C00 : (l == 1) ? 16'h4000 : 16'h3800;
        2:       scalePat[l] = 16'h4000;
        3:       scalePat[l] = 16'h3800;
        4:       scalePat[l] = 16'h0000;
        default: scalePat[l] = 16'h3C00;
      endcase
      for (int k = 0; k < T; k++) begin
        case (scen)
          1:       accPat[l][k] = 16'h3C00;
          3:       accPat[l][k] = 16'(16'h4000 + l * T + k);
          4:       accPat[l][k] = (k % 7 == 3) ? 16'h7E00 : 16'(16'h3C00 + k);
          default: accPat[l][k] = 16'(l * T + k);
        endcase
        acc_i[l][k] = accPat[l][k];
      end
      scale_i[l] = scalePat[l];
    end
    for (int l = 0; l < P; l++) begin
      for (int b = 0; b < NB; b++) begin
        e.lane = 2'(l);
        e.beat = 3'(b);
        e.last = (l == P - 1) && (b == NB - 1);
        e.data = '0;
        for (int j = 0; j < B; j++)
          e.data[j*16 +: 16] = modelMul(accPat[l][b*B + j], scalePat[l]);
        sb.push_back(e);
      end
    end
  endtask

  // Accept beats until the scoreboard empties; optionally stall with a
  // 1,0,0,1 ready pattern, re-pulse start, or hit reset after injectAt beats
  task automatic drainTransfer(input bit stallMode, input int injectAt, input int injectKind);
    int           accepted = 0;
    int           cycles = 0;
    bit           prevStall = 0;
    bit           ready;
    logic [255:0] snapData = '0;
    logic [1:0]   snapLane = '0;
    logic [2:0]   snapBeat = '0;
    logic         snapLast = 1'b0;
    exp_t         e;
    while (sb.size() != 0 && cycles < 400) begin
      ready       = stallMode ? readyPattern[cycles % 4] : 1'b1;
      out_ready_i = ready;
      start_i     = 1'b0;
      if (injectKind == 1 && accepted == injectAt) begin
        start_i = 1'b1;
        acc_i   = {(P*T){16'h1234}};
        scale_i = {P{16'h4000}};
      end
      if (injectKind == 2 && accepted == injectAt) begin
        rst_i = 1'b1;
        #1;
        checkOutput("rst_mid_valid", out_valid_o, 1'b0);
        checkOutput("rst_mid_done",  done_o,      1'b0);
        checkOutput("rst_mid_busy",  busy_o,      1'b0);
        checkOutput("rst_mid_lane",  out_lane_o,  2'd0);
        checkOutput("rst_mid_beat",  out_beat_o,  3'd0);
        checkOutput("rst_mid_data",  out_data_o,  256'h0);
        sb.delete();
        @(posedge clk); #1;
        checkOutput("rst_hold_done", done_o, 1'b0);
        rst_i = 1'b0;
        return;
      end
      checkOutput("stream_valid", out_valid_o, 1'b1);
      if (prevStall) begin
        checkOutput("hold_data", out_data_o, snapData);
        checkOutput("hold_lane", out_lane_o, snapLane);
        checkOutput("hold_beat", out_beat_o, snapBeat);
        checkOutput("hold_last", out_last_o, snapLast);
      end
      if (out_valid_o && ready) begin
        e = sb.pop_front();
        checkOutput("beat_lane", out_lane_o, e.lane);
        checkOutput("beat_idx",  out_beat_o, e.beat);
        checkOutput("beat_last", out_last_o, e.last);
        checkOutput("beat_data", out_data_o, e.data);
        accepted++;
      end
      prevStall = out_valid_o && !ready;
      snapData  = out_data_o;
      snapLane  = out_lane_o;
      snapBeat  = out_beat_o;
      snapLast  = out_last_o;
      @(posedge clk); #1;
      cycles++;
    end
    start_i = 1'b0;
    if (sb.size() != 0) begin
      checkOutput("drain_timeout", 256'(sb.size()), 256'h0);
      sb.delete();
    end
    if (!stallMode) checkOutput("beat_cycles", 256'(cycles), 256'(P * NB));
  endtask

  // Start a capture, check the LOAD cycle, drain, then check the DONE pulse
  // and that a start during DONE is ignored
  task automatic runTransfer(input bit stallMode, input int injectAt, input int injectKind);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    checkOutput("load_busy",  busy_o,      1'b1);
    checkOutput("load_valid", out_valid_o, 1'b0);
    @(posedge clk); #1;
    checkOutput("first_lane", out_lane_o, 2'd0);
    checkOutput("first_beat", out_beat_o, 3'd0);
    drainTransfer(stallMode, injectAt, injectKind);
    if (injectKind != 2) begin
      checkOutput("done_pulse", done_o,      1'b1);
      checkOutput("done_valid", out_valid_o, 1'b0);
      checkOutput("done_busy",  busy_o,      1'b1);
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      checkOutput("done_clear", done_o, 1'b0);
      checkOutput("idle_busy",  busy_o, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_i       = 1'b1;
    start_i     = 1'b0;
    out_ready_i = 1'b0;
    acc_i       = '0;
    scale_i     = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", out_valid_o, 1'b0);
    checkOutput("reset_last",  out_last_o,  1'b0);
    checkOutput("reset_done",  done_o,      1'b0);
    checkOutput("reset_busy",  busy_o,      1'b0);
    checkOutput("reset_lane",  out_lane_o,  2'd0);
    checkOutput("reset_beat",  out_beat_o,  3'd0);
    checkOutput("reset_data",  out_data_o,  256'h0);
    rst_i = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_reset_busy", busy_o, 1'b0);

    $display("[TB] identity scale, ready high");
    applyStimulus(0);
    runTransfer(1'b0, 0, 0);

    $display("[TB] per-lane scales 1.0 / 2.0 / 0.5");
    applyStimulus(1);
    runTransfer(1'b0, 0, 0);

    $display("[TB] ready pattern 1,0,0,1 with doubling");
    applyStimulus(2);
    runTransfer(1'b1, 0, 0);

    $display("[TB] start re-pulsed mid-stream");
    applyStimulus(3);
    runTransfer(1'b0, 5, 1);

    $display("[TB] reset at beat 10, then restart");
    applyStimulus(0);
    runTransfer(1'b0, 10, 2);
    @(posedge clk); #1;
    applyStimulus(2);
    runTransfer(1'b0, 0, 0);

    $display("[TB] zero scale with NaN elements");
    applyStimulus(4);
    runTransfer(1'b0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
